// File: rtl/skewed_input_buffer_if.sv
// Lane write/read handshake and status bundle for skewed_input_buffer.
// master drives writes, read and flush; slave returns data, valids and status.
interface skewed_input_buffer_if #(
    parameter int ROWS   = 4,
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                            flush;
    logic                            read;
    logic [ROWS-1:0]                 wr_en;
    logic [ROWS-1:0][DWIDTH-1:0]     i_data;
    logic [ROWS-1:0]                 o_valid;
    logic [ROWS-1:0][DWIDTH-1:0]     o_data;
    logic [ROWS-1:0]                 empty;
    logic [ROWS-1:0]                 full;
    logic [ROWS-1:0][CW-1:0]         count;
    logic                            busy;
    logic [ROWS-1:0]                 ovf_err;
    logic [ROWS-1:0]                 udf_err;

    modport master (
        output flush, read, wr_en, i_data,
        input  o_valid, o_data, empty, full, count, busy, ovf_err, udf_err
    );

    modport slave (
        input  flush, read, wr_en, i_data,
        output o_valid, o_data, empty, full, count, busy, ovf_err, udf_err
    );
endinterface

// File: rtl/skewed_input_buffer.sv
// Per-row FIFOs feeding a systolic array; lane i reads i cycles after lane 0.
// Latency: 1 cycle from lane read strobe to o_valid/o_data.
// Backpressure: none; writes to a full lane are dropped (ovf_err), reads of an empty lane return zero (udf_err).
module skewed_input_buffer #(
    parameter int ROWS    = 4,
    parameter int DWIDTH  = 8,
    parameter int DEPTH   = 16,
    parameter int SKEW_EN = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    skewed_input_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ROWS-1:0]              rd;
    logic [ROWS-1:0]              rd_acc;
    logic [ROWS-1:0]              wr_acc;
    logic [ROWS-1:0]              stage;
    logic [AW-1:0]                wptr [ROWS];
    logic [AW-1:0]                rptr [ROWS];
    logic [CW-1:0]                cnt  [ROWS];
    logic [DWIDTH-1:0]            mem  [ROWS][DEPTH];
    logic [ROWS-1:0]              vld_q;
    logic [ROWS-1:0][DWIDTH-1:0]  dat_q;
    logic [ROWS-1:0]              ovf_q;
    logic [ROWS-1:0]              udf_q;

    // stage[i] holds lane i's delayed read strobe; stage[0] is never used and stays 0
    always_comb begin
        rd     = '0;
        rd_acc = '0;
        wr_acc = '0;
        rd[0]  = bus.read;
        for (int i = 1; i < ROWS; i++) begin
            rd[i] = (SKEW_EN != 0) ? stage[i] : bus.read;
        end
        for (int i = 0; i < ROWS; i++) begin
            rd_acc[i] = rd[i] && (cnt[i] != '0);
            wr_acc[i] = bus.wr_en[i] && ((cnt[i] != CW'(DEPTH)) || rd_acc[i]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage <= '0;
        end else if (bus.flush) begin
            stage <= '0;
        end else begin
            stage[0] <= 1'b0;
            for (int i = 1; i < ROWS; i++) begin
                stage[i] <= (SKEW_EN != 0) && rd[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ROWS; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            vld_q <= '0;
            dat_q <= '0;
            ovf_q <= '0;
            udf_q <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < ROWS; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            vld_q <= '0;
            dat_q <= '0;
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                if (wr_acc[i]) wptr[i] <= wptr[i] + AW'(1);
                if (rd_acc[i]) rptr[i] <= rptr[i] + AW'(1);
                case ({wr_acc[i], rd_acc[i]})
                    2'b10:   cnt[i] <= cnt[i] + CW'(1);
                    2'b01:   cnt[i] <= cnt[i] - CW'(1);
                    default: cnt[i] <= cnt[i];
                endcase
                vld_q[i] <= rd_acc[i];
                dat_q[i] <= rd_acc[i] ? mem[i][rptr[i]] : '0;
                if (bus.wr_en[i] && !wr_acc[i]) ovf_q[i] <= 1'b1;
                if (rd[i] && (cnt[i] == '0))    udf_q[i] <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ROWS; i++) begin
            if (wr_acc[i] && !bus.flush) mem[i][wptr[i]] <= bus.i_data[i];
        end
    end

    always_comb begin
        bus.count = '0;
        bus.empty = '0;
        bus.full  = '0;
        for (int i = 0; i < ROWS; i++) begin
            bus.count[i] = cnt[i];
            bus.empty[i] = (cnt[i] == '0);
            bus.full[i]  = (cnt[i] == CW'(DEPTH));
        end
        bus.o_valid = vld_q;
        bus.o_data  = dat_q;
        bus.ovf_err = ovf_q;
        bus.udf_err = udf_q;
        bus.busy    = (|stage) || (|vld_q);
    end
endmodule
